// File: rtl/fm_ctrl_gen.sv
// FM control-word generator: scales a modulating sample, offsets the carrier,
// and ramps ctrl linearly to each new target over 2^INTERP_LOG2 clocks.
module fm_ctrl_gen #(
    parameter int DEV_SHIFT   = 8,
    parameter int INTERP_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] carrier,
    input  logic [15:0] dev,
    input  logic [15:0] mod_in,
    input  logic        mod_valid,
    output logic        mod_ready,
    output logic [31:0] ctrl,
    output logic        underrun
);

    localparam int N = 1 << INTERP_LOG2;
    localparam logic [8:0] LAST = 9'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        PREP,
        RAMP
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [15:0] mod_r;
    logic [15:0] dev_r;
    logic [31:0] car_r;
    logic [31:0] p_r;
    logic [31:0] t_r;
    logic [31:0] s_r;
    logic [8:0]  cnt;
    logic [8:0]  cnt_d;
    logic [31:0] ctrl_d;
    logic        und_d;
    logic        last;
    logic        accept;
    logic [31:0] prod;
    logic [31:0] tgt;
    logic [31:0] diff;
    logic [31:0] step;

    assign last      = (state == RAMP) && (cnt == LAST);
    assign mod_ready = (state == IDLE) || last;
    assign accept    = mod_valid && mod_ready;

    // Low 32 bits of the widened signed product are exact: |P| < 2^31.
    assign prod = $signed({{16{mod_r[15]}}, mod_r}) * $signed({16'd0, dev_r});
    assign tgt  = car_r + 32'($signed(p_r) >>> DEV_SHIFT);
    assign diff = tgt - ctrl;
    assign step = 32'($signed(diff) >>> INTERP_LOG2);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ctrl_d  = ctrl;
        und_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_d = MUL;
            end
            MUL: begin
                state_d = PREP;
            end
            PREP: begin
                state_d = RAMP;
                cnt_d   = 9'd0;
            end
            RAMP: begin
                if (!last) begin
                    ctrl_d = ctrl + s_r;
                    cnt_d  = cnt + 9'd1;
                end else begin
                    // Land exactly on the target so step truncation never drifts.
                    ctrl_d  = t_r;
                    state_d = accept ? MUL : IDLE;
                    und_d   = !accept;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mod_r    <= '0;
            dev_r    <= '0;
            car_r    <= '0;
            p_r      <= '0;
            t_r      <= '0;
            s_r      <= '0;
            cnt      <= '0;
            ctrl     <= '0;
            underrun <= 1'b0;
        end else begin
            if (accept) begin
                mod_r <= mod_in;
                dev_r <= dev;
                car_r <= carrier;
            end
            if (state == MUL) p_r <= prod;
            if (state == PREP) begin
                t_r <= tgt;
                s_r <= step;
            end
            cnt      <= cnt_d;
            ctrl     <= ctrl_d;
            underrun <= und_d;
        end
    end

endmodule

// File: tb/tb_fm_ctrl_gen.sv
// Directed bench for fm_ctrl_gen: default config plus a DEV_SHIFT=0,
// INTERP_LOG2=0 instance for the negative/wrap case.
module tb_fm_ctrl_gen;

    logic        clk;
    logic        rst;
    logic [31:0] carrier;
    logic [15:0] dev;
    logic [15:0] mod_in;
    logic        va;
    logic        vb;
    logic        ready_a;
    logic        ready_b;
    logic [31:0] ctrl_a;
    logic [31:0] ctrl_b;
    logic        und_a;
    logic        und_b;

    int checks = 0;
    int errors = 0;

    fm_ctrl_gen dut_a (
        .clk      (clk),
        .rst      (rst),
        .carrier  (carrier),
        .dev      (dev),
        .mod_in   (mod_in),
        .mod_valid(va),
        .mod_ready(ready_a),
        .ctrl     (ctrl_a),
        .underrun (und_a)
    );

    fm_ctrl_gen #(.DEV_SHIFT(0), .INTERP_LOG2(0)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .carrier  (carrier),
        .dev      (dev),
        .mod_in   (mod_in),
        .mod_valid(vb),
        .mod_ready(ready_b),
        .ctrl     (ctrl_b),
        .underrun (und_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] smp   [3];
    logic [31:0] tgt   [3];
    logic [31:0] first [3];
    int          n;
    int          und_seen;

    initial begin
        smp[0] = 16'h0020; tgt[0] = 32'h0100_0020; first[0] = 32'h0100_0011;
        smp[1] = 16'hFFF0; tgt[1] = 32'h00FF_FFF0; first[1] = 32'h0100_001D;
        smp[2] = 16'h0100; tgt[2] = 32'h0100_0100; first[2] = 32'h0100_0001;

        rst = 1'b1;
        carrier = '0;
        dev = '0;
        mod_in = '0;
        va = 1'b0;
        vb = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #3 rst = 1'b0;
        #1;
        check("rst_ctrl_a", ctrl_a, 32'h0);
        check("rst_und_a", {31'd0, und_a}, 32'h0);
        check("rst_rdy_a", {31'd0, ready_a}, 32'h1);
        check("rst_ctrl_b", ctrl_b, 32'h0);
        tick();
        tick();
        #3 rst = 1'b1;
        tick();

        // Basic ramp
        carrier = 32'h0100_0000;
        dev = 16'h0100;
        mod_in = 16'h0010;
        va = 1'b1;
        check("basic_rdy", {31'd0, ready_a}, 32'h1);
        tick();
        va = 1'b0;
        mod_in = 16'h7FFF;
        check("busy_rdy", {31'd0, ready_a}, 32'h0);
        tick();
        tick();
        check("hold_prep", ctrl_a, 32'h0);
        tick();
        check("ramp_k3", ctrl_a, 32'h0010_0001);
        repeat (14) tick();
        check("ramp_k17", ctrl_a, 32'h00F0_000F);
        check("rdy_last", {31'd0, ready_a}, 32'h1);
        tick();
        check("ramp_k18", ctrl_a, 32'h0100_0010);
        check("und_pulse", {31'd0, und_a}, 32'h1);
        tick();
        check("und_clear", {31'd0, und_a}, 32'h0);
        check("ctrl_hold", ctrl_a, 32'h0100_0010);
        tick();
        check("und_idle", {31'd0, und_a}, 32'h0);
        check("b_quiet", ctrl_b, 32'h0);

        // Negative / wrap on the single-step instance
        carrier = 32'h8000_0000;
        dev = 16'hFFFF;
        mod_in = 16'h8000;
        vb = 1'b1;
        tick();
        vb = 1'b0;
        tick();
        tick();
        tick();
        check("wrap_ctrl", ctrl_b, 32'h0000_8000);
        check("wrap_und", {31'd0, und_b}, 32'h1);
        tick();
        check("wrap_und_clr", {31'd0, und_b}, 32'h0);

        // Streaming with mod_valid held high
        carrier = 32'h0100_0000;
        dev = 16'h0100;
        und_seen = 0;
        mod_in = smp[0];
        va = 1'b1;
        check("stream_rdy0", {31'd0, ready_a}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (und_a) und_seen++;
            if (i > 0) check("stream_tgt", ctrl_a, tgt[i-1]);
            mod_in = 16'h7FFF;
            n = 0;
            while (!ready_a && n < 40) begin
                tick();
                n++;
                if (und_a) und_seen++;
                if (n == 3) check("stream_step", ctrl_a, first[i]);
            end
            check("stream_gap", n, 17);
            if (i < 2) mod_in = smp[i+1];
            else va = 1'b0;
        end
        tick();
        check("stream_last", ctrl_a, tgt[2]);
        check("stream_und_end", {31'd0, und_a}, 32'h1);
        check("stream_no_und", und_seen, 0);
        tick();

        // Reset in the middle of a ramp (cnt=5)
        mod_in = 16'h0010;
        va = 1'b1;
        tick();
        va = 1'b0;
        repeat (7) tick();
        check("mid_ctrl", ctrl_a, 32'h0100_00B5);
        #2 rst = 1'b0;
        #1;
        check("mrst_ctrl", ctrl_a, 32'h0);
        check("mrst_und", {31'd0, und_a}, 32'h0);
        check("mrst_rdy", {31'd0, ready_a}, 32'h1);
        #1 rst = 1'b1;
        tick();
        check("mrst_und_after", {31'd0, und_a}, 32'h0);
        check("mrst_ctrl_after", ctrl_a, 32'h0);

        mod_in = 16'h0010;
        va = 1'b1;
        tick();
        va = 1'b0;
        tick();
        tick();
        tick();
        check("re_k3", ctrl_a, 32'h0010_0001);
        repeat (15) tick();
        check("re_k18", ctrl_a, 32'h0100_0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
